// File: rtl/pipeline_trace_monitor.sv
// Run monitor for the 5-stage RV32I pipeline: event counters, show-ahead retire
// trace FIFO and a run FSM that ends on a register-watch pass or a cycle watchdog.
module pipeline_trace_monitor #(
   parameter int XLEN           = 32,
   parameter int TRACE_DEPTH    = 16,
   parameter int CNT_W          = 32,
   parameter int WATCH_REG      = 20,
   parameter int WATCH_VAL      = 100,
   parameter int TIMEOUT_CYCLES = 80
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_wb_valid,
   input  logic [XLEN-1:0]  i_wb_pc,
   input  logic [31:0]      i_wb_instr,
   input  logic             i_wb_we,
   input  logic [4:0]       i_wb_rd,
   input  logic [XLEN-1:0]  i_wb_data,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic             i_trace_ready,
   output logic             o_trace_valid,
   output logic [XLEN-1:0]  o_trace_pc,
   output logic [31:0]      o_trace_instr,
   output logic [4:0]       o_trace_rd,
   output logic [XLEN-1:0]  o_trace_data,
   output logic             o_trace_overflow,
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic [CNT_W-1:0] o_retire_cnt,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
   output logic [1:0]       o_state,
   output logic             o_done,
   output logic             o_pass
);

   localparam int AW = $clog2(TRACE_DEPTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PASS = 2'd2, S_TIMEOUT = 2'd3} state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } entry_t;

   state_t          state, state_nxt;
   entry_t          mem [TRACE_DEPTH];
   entry_t          head, wr_entry;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            is_bubble, qret, pass_hit, timeout_hit;
   logic            full, pop, do_push;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // The start cycle itself is never counted or traced.
   assign is_bubble   = (i_wb_instr == 32'h0000_0013) || (i_wb_instr == 32'h0);
   assign qret        = i_wb_valid && (state == S_RUN) && !i_start && !is_bubble;
   assign pass_hit    = qret && i_wb_we && (WATCH_REG != 0) &&
                        (i_wb_rd == 5'(WATCH_REG)) && (i_wb_data == XLEN'(WATCH_VAL));
   assign timeout_hit = (state == S_RUN) && !pass_hit &&
                        (o_cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (i_start) state_nxt = S_RUN;
      else if (state == S_RUN) begin
         if (pass_hit)         state_nxt = S_PASS;
         else if (timeout_hit) state_nxt = S_TIMEOUT;
      end
   end

   always_comb begin
      o_state = state;
      o_done  = (state == S_PASS) || (state == S_TIMEOUT);
      o_pass  = (state == S_PASS);
   end

   always_ff @(posedge clk) begin
      if (reset || i_start) begin
         o_cycle_cnt  <= '0;
         o_retire_cnt <= '0;
         o_stall_cnt  <= '0;
         o_flush_cnt  <= '0;
      end else if (state == S_RUN) begin
         o_cycle_cnt <= sat_inc(o_cycle_cnt);
         if (qret)    o_retire_cnt <= sat_inc(o_retire_cnt);
         if (i_stall) o_stall_cnt  <= sat_inc(o_stall_cnt);
         if (i_flush) o_flush_cnt  <= sat_inc(o_flush_cnt);
      end
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign full    = (count == (AW+1)'(TRACE_DEPTH));
   assign pop     = i_trace_ready && (count != '0);
   assign do_push = qret && (!full || pop);

   always_comb begin
      wr_entry.pc    = i_wb_pc;
      wr_entry.instr = i_wb_instr;
      wr_entry.rd    = i_wb_we ? i_wb_rd   : 5'd0;
      wr_entry.data  = i_wb_we ? i_wb_data : '0;
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

   always_ff @(posedge clk) begin
      if (reset || i_start) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         o_trace_overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
         if (qret && full && !pop) o_trace_overflow <= 1'b1;
      end
   end

   // Storage is not reset, so the head is masked while the FIFO is empty.
   assign head          = mem[rd_ptr];
   assign o_trace_valid = (count != '0);
   assign o_trace_pc    = o_trace_valid ? head.pc    : '0;
   assign o_trace_instr = o_trace_valid ? head.instr : '0;
   assign o_trace_rd    = o_trace_valid ? head.rd    : '0;
   assign o_trace_data  = o_trace_valid ? head.data  : '0;

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Directed bench for pipeline_trace_monitor: a per-cycle vector table plus
// hand sequences for pass, timeout, overflow, restart and reset.
module tb_pipeline_trace_monitor;

   localparam logic [31:0] ADDI  = 32'h0010_0093;
   localparam logic [31:0] STORE = 32'h0011_2023;

   logic        clk = 1'b0;
   logic        reset, i_start, i_wb_valid, i_wb_we, i_stall, i_flush, i_trace_ready;
   logic [31:0] i_wb_pc, i_wb_instr, i_wb_data;
   logic [4:0]  i_wb_rd;
   logic        o_trace_valid, o_trace_overflow, o_done, o_pass;
   logic [31:0] o_trace_pc, o_trace_instr, o_trace_data;
   logic [4:0]  o_trace_rd;
   logic [31:0] o_cycle_cnt, o_retire_cnt, o_stall_cnt, o_flush_cnt;
   logic [1:0]  o_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_trace_monitor #(
      .XLEN(32), .TRACE_DEPTH(16), .CNT_W(32),
      .WATCH_REG(20), .WATCH_VAL(100), .TIMEOUT_CYCLES(80)
   ) dut (
      .clk(clk), .reset(reset), .i_start(i_start),
      .i_wb_valid(i_wb_valid), .i_wb_pc(i_wb_pc), .i_wb_instr(i_wb_instr),
      .i_wb_we(i_wb_we), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
      .i_stall(i_stall), .i_flush(i_flush), .i_trace_ready(i_trace_ready),
      .o_trace_valid(o_trace_valid), .o_trace_pc(o_trace_pc),
      .o_trace_instr(o_trace_instr), .o_trace_rd(o_trace_rd),
      .o_trace_data(o_trace_data), .o_trace_overflow(o_trace_overflow),
      .o_cycle_cnt(o_cycle_cnt), .o_retire_cnt(o_retire_cnt),
      .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt),
      .o_state(o_state), .o_done(o_done), .o_pass(o_pass)
   );

   typedef struct {
      logic        st, vl;
      logic [31:0] ins;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] dat;
      logic        stl, fl, rdy;
      logic [1:0]  e_st;
      int          e_cyc, e_ret, e_stl, e_fl;
      logic        e_tv;
      logic [4:0]  e_rd;
      logic [31:0] e_dat;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic vl, input logic [31:0] ins, input logic we,
                        input logic [4:0] rd, input logic [31:0] dat,
                        input logic stl, input logic fl, input logic rdy);
      i_start = st; i_wb_valid = vl; i_wb_instr = ins; i_wb_we = we;
      i_wb_rd = rd; i_wb_data = dat; i_stall = stl; i_flush = fl; i_trace_ready = rdy;
      i_wb_pc = 32'h100 + dat;
   endtask

   task automatic idle(input logic rdy);
      drive(0, 0, 0, 0, 0, 0, 0, 0, rdy);
      step();
   endtask

   task automatic retire(input logic [4:0] rd, input logic [31:0] dat, input logic rdy);
      drive(0, 1, ADDI, 1, rd, dat, 0, 0, rdy);
      step();
   endtask

   task automatic start_run();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      i_start = 1'b0;
   endtask

   initial begin
      vt[0]  = '{1,1,ADDI, 1,1,99, 1,1,0, 2'd1, 0,0,0,0, 0,0,0};
      vt[1]  = '{0,1,ADDI, 1,1,1,  1,0,0, 2'd1, 1,1,1,0, 1,1,1};
      vt[2]  = '{0,1,32'h13,1,1,7, 1,1,0, 2'd1, 2,1,2,1, 1,1,1};
      vt[3]  = '{0,1,32'h0, 1,1,8,  0,0,0, 2'd1, 3,1,2,1, 1,1,1};
      vt[4]  = '{0,1,ADDI, 1,1,2,  0,1,0, 2'd1, 4,2,2,2, 1,1,1};
      vt[5]  = '{0,1,ADDI, 1,1,3,  1,0,0, 2'd1, 5,3,3,2, 1,1,1};
      vt[6]  = '{0,1,STORE,0,2,55, 1,0,0, 2'd1, 6,4,4,2, 1,1,1};
      vt[7]  = '{0,0,ADDI, 1,1,9,  0,0,1, 2'd1, 7,4,4,2, 1,1,2};
      vt[8]  = '{0,0,0,    0,0,0,  0,0,1, 2'd1, 8,4,4,2, 1,1,3};
      vt[9]  = '{0,0,0,    0,0,0,  0,0,1, 2'd1, 9,4,4,2, 1,0,0};
      vt[10] = '{0,0,0,    0,0,0,  0,0,1, 2'd1,10,4,4,2, 0,0,0};
      vt[11] = '{0,0,0,    0,0,0,  0,0,1, 2'd1,11,4,4,2, 0,0,0};

      // Reset beats a simultaneous start and retire.
      reset = 1'b1;
      drive(1, 1, ADDI, 1, 20, 100, 1, 1, 0);
      step(); step();
      chk("rst_state", o_state, 0);
      chk("rst_cycle", o_cycle_cnt, 0);
      chk("rst_retire", o_retire_cnt, 0);
      chk("rst_tvalid", o_trace_valid, 0);
      chk("rst_done", o_done, 0);
      reset = 1'b0;
      drive(0, 1, ADDI, 1, 1, 5, 1, 1, 0);
      step();
      chk("idle_retire", o_retire_cnt, 0);
      chk("idle_stall", o_stall_cnt, 0);
      chk("idle_tvalid", o_trace_valid, 0);

      for (int i = 0; i < 12; i++) begin
         drive(vt[i].st, vt[i].vl, vt[i].ins, vt[i].we, vt[i].rd, vt[i].dat,
               vt[i].stl, vt[i].fl, vt[i].rdy);
         step();
         chk($sformatf("v%0d_state", i), o_state, vt[i].e_st);
         chk($sformatf("v%0d_cycle", i), o_cycle_cnt, vt[i].e_cyc);
         chk($sformatf("v%0d_retire", i), o_retire_cnt, vt[i].e_ret);
         chk($sformatf("v%0d_stall", i), o_stall_cnt, vt[i].e_stl);
         chk($sformatf("v%0d_flush", i), o_flush_cnt, vt[i].e_fl);
         chk($sformatf("v%0d_tvalid", i), o_trace_valid, vt[i].e_tv);
         chk($sformatf("v%0d_hrd", i), o_trace_rd, vt[i].e_rd);
         chk($sformatf("v%0d_hdata", i), o_trace_data, vt[i].e_dat);
      end

      // Pass at RUN cycle 10; near-miss writes beforehand must not pass.
      start_run();
      retire(20, 99, 0);
      drive(0, 1, STORE, 0, 20, 100, 0, 0, 0); step();
      for (int k = 0; k < 8; k++) idle(0);
      chk("pre_pass_state", o_state, 1);
      chk("pre_pass_cycle", o_cycle_cnt, 10);
      retire(20, 100, 0);
      chk("pass_state", o_state, 2);
      chk("pass_pass", o_pass, 1);
      chk("pass_done", o_done, 1);
      chk("pass_retire", o_retire_cnt, 3);
      chk("pass_cycle", o_cycle_cnt, 11);
      idle(0); retire(1, 7, 0);
      chk("pass_hold_cycle", o_cycle_cnt, 11);
      chk("pass_hold_retire", o_retire_cnt, 3);
      chk("pass_head_data", o_trace_data, 99);
      idle(1);
      chk("pass_drain_rd", o_trace_rd, 0);
      chk("pass_drain_data", o_trace_data, 0);
      idle(1);
      chk("pass_drain_rd2", o_trace_rd, 20);
      chk("pass_drain_data2", o_trace_data, 100);
      // Reset while in PASS with an entry still queued.
      reset = 1'b1; idle(0); reset = 1'b0;
      chk("rp_state", o_state, 0);
      chk("rp_pass", o_pass, 0);
      chk("rp_cycle", o_cycle_cnt, 0);
      chk("rp_retire", o_retire_cnt, 0);
      chk("rp_tvalid", o_trace_valid, 0);
      chk("rp_hdata", o_trace_data, 0);
      chk("rp_hpc", o_trace_pc, 0);

      // Watchdog timeout after 80 RUN cycles.
      start_run();
      for (int k = 0; k < 79; k++) idle(0);
      chk("to_pre_state", o_state, 1);
      chk("to_pre_cycle", o_cycle_cnt, 79);
      idle(0);
      chk("to_state", o_state, 3);
      chk("to_cycle", o_cycle_cnt, 80);
      chk("to_pass", o_pass, 0);
      chk("to_done", o_done, 1);
      idle(0);
      chk("to_hold_cycle", o_cycle_cnt, 80);

      // Pass in the last budget cycle wins over timeout.
      start_run();
      for (int k = 0; k < 79; k++) idle(0);
      retire(20, 100, 0);
      chk("tie_state", o_state, 2);
      chk("tie_cycle", o_cycle_cnt, 80);

      // Overflow: 20 retires into 16 entries.
      start_run();
      for (int k = 1; k <= 20; k++) begin
         retire(3, k, 0);
         if (k == 16) chk("ovf_at16", o_trace_overflow, 0);
         if (k == 17) chk("ovf_at17", o_trace_overflow, 1);
      end
      chk("ovf_retire", o_retire_cnt, 20);
      chk("ovf_head", o_trace_data, 1);
      // Mid-run restart with entries queued.
      start_run();
      chk("rs_state", o_state, 1);
      chk("rs_retire", o_retire_cnt, 0);
      chk("rs_cycle", o_cycle_cnt, 0);
      chk("rs_tvalid", o_trace_valid, 0);
      chk("rs_ovf", o_trace_overflow, 0);

      // Fill, then push with pop while full, then drain in order.
      for (int k = 1; k <= 16; k++) retire(4, k, 0);
      retire(4, 17, 1);
      chk("fp_ovf", o_trace_overflow, 0);
      chk("fp_head", o_trace_data, 2);
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("drain%0d", k), o_trace_data, k + 2);
         idle(1);
      end
      chk("drain_empty", o_trace_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_trace_monitor.md
Name: pipeline_trace_monitor

Overview:
Synthesizable, parametrised run monitor for the 5-stage RV32I pipeline. It taps the WB stage and the hazard unit's stall/flush signals, and counts cycles, retired instructions, stalls and flushes. Retired instructions go into a show-ahead trace FIFO that a debug port drains. A run FSM ends the run on a register-watch pass condition or on a cycle watchdog timeout, so FPGA builds get self-checking runs without the simulation bench.

Parameters:
XLEN, 32, datapath/register width
TRACE_DEPTH, 16, trace FIFO entries; power of 2, >= 2
CNT_W, 32, width of all event counters
WATCH_REG, 20, architectural register index whose write ends the run with pass
WATCH_VAL, 100, value that WATCH_REG must receive for pass
TIMEOUT_CYCLES, 80, RUN-state cycle budget before timeout; >= 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
i_start  in  1  one-cycle pulse; starts or restarts a run
i_wb_valid  in  1  WB stage holds a real instruction this cycle
i_wb_pc  in  XLEN  PC of the WB instruction
i_wb_instr  in  32  WB instruction word
i_wb_we  in  1  WB register write enable
i_wb_rd  in  5  WB destination register
i_wb_data  in  XLEN  WB write data
i_stall  in  1  pipeline stall this cycle
i_flush  in  1  pipeline flush this cycle
i_trace_ready  in  1  consumer pops the head entry
o_trace_valid  out  1  FIFO not empty
o_trace_pc  out  XLEN  head entry PC
o_trace_instr  out  32  head entry instruction
o_trace_rd  out  5  head entry rd; 0 when the entry had no write
o_trace_data  out  XLEN  head entry write data; 0 when the entry had no write
o_trace_overflow  out  1  sticky: at least one retire was dropped
o_cycle_cnt  out  CNT_W  cycles spent in RUN
o_retire_cnt  out  CNT_W  qualified retires
o_stall_cnt  out  CNT_W  stall cycles
o_flush_cnt  out  CNT_W  flush cycles
o_state  out  2  0=IDLE, 1=RUN, 2=PASS, 3=TIMEOUT
o_done  out  1  state is PASS or TIMEOUT
o_pass  out  1  state is PASS

Behaviour:
- Reset:
  - State goes to IDLE.
  - All counters go to 0.
  - FIFO is emptied: o_trace_valid=0, and o_trace_pc/instr/rd/data read 0.
  - o_trace_overflow=0, o_done=0, o_pass=0.
  - Reset wins over every other input in the same cycle.
- Qualified retire:
  - Condition: i_wb_valid=1, state is RUN, and i_wb_instr is neither 32'h00000013 nor 0.
  - Bubbles are never counted or traced.
- FSM:
  - IDLE -> RUN on i_start.
  - RUN -> PASS on a qualified retire with i_wb_we=1, i_wb_rd==WATCH_REG, i_wb_data==WATCH_VAL, and WATCH_REG!=0.
  - RUN -> TIMEOUT when o_cycle_cnt==TIMEOUT_CYCLES-1 and pass is not met in that cycle. Pass wins a tie.
  - PASS and TIMEOUT hold until reset or i_start.
  - i_start in any state, including mid-run, restarts the run. It enters RUN and clears counters, FIFO and overflow.
  - In the i_start cycle, no input is counted or traced.
- Counters:
  - Increment only in RUN and saturate at all-ones.
  - o_cycle_cnt increments every RUN cycle.
  - i_stall and i_flush are counted independently; both increment when both are high.
  - The retire that causes PASS is counted and traced.
- Trace FIFO:
  - Show-ahead: the head is on the outputs whenever o_trace_valid=1.
  - A push at edge N makes the entry visible after edge N.
  - A pop occurs when i_trace_ready and o_trace_valid are both 1.
  - Pop while empty: ignored.
  - Push while full without a simultaneous pop: entry dropped and o_trace_overflow set.
  - Push while full with a simultaneous pop: both happen, occupancy stays full, no overflow.
  - Read/write pointers wrap modulo TRACE_DEPTH.
  - An entry with i_wb_we=0 stores rd=0 and data=0.
  - The FIFO can still be drained in PASS, TIMEOUT and IDLE.
- All outputs are registered, or decoded from registered state.

Test Plan:
- Reset, then i_start, then 5 retires of addi x1 (data 1..5) -> o_retire_cnt=5, o_trace_valid=1, head rd=1 data=1, o_state=1.
- Retire x20<=100 at RUN cycle 10 -> o_state=2, o_pass=1, o_done=1, o_retire_cnt includes it, o_cycle_cnt frozen at 11.
- TIMEOUT_CYCLES=80, no pass -> o_state=3 after 80 RUN cycles, o_cycle_cnt=80, o_pass=0. Pass arriving in cycle 79 -> PASS instead.
- Interleave bubbles (0x13, 0) with 3 real retires, i_stall high 4 cycles, i_flush high 2 cycles (1 overlapping a stall) -> retire=3, stall=4, flush=2.
- TRACE_DEPTH=16, 20 retires with i_trace_ready=0 -> 16 entries, overflow=1. Then push and pop together while full -> no extra drop. Draining 16 entries returns them in order, then o_trace_valid=0.
- i_start mid-run with 6 entries queued -> counters=0, FIFO empty, overflow=0, o_state=1. Reset during PASS -> IDLE, all outputs 0.
